// File: rtl/exec_unit_if.sv
// Instruction/debug bus of exec_unit: decoded instruction fields in,
// debug read port, result and flags out.
interface exec_unit_if #(
    parameter int DW = 16
);
    logic [3:0]    OP;
    logic [2:0]    LSEL;
    logic [2:0]    RSEL;
    logic [2:0]    OSEL;
    logic          LOUT;
    logic          ROUT;
    logic          OIN;
    logic [DW-1:0] Rbus;
    logic [2:0]    DSEL;
    logic [DW-1:0] DOUT;
    logic [DW-1:0] RESULT;
    logic          WE;
    logic          ZF;
    logic          CF;

    // decoder / testbench side
    modport master (
        output OP, LSEL, RSEL, OSEL, LOUT, ROUT, OIN, Rbus, DSEL,
        input  DOUT, RESULT, WE, ZF, CF
    );

    // execution unit side
    modport slave (
        input  OP, LSEL, RSEL, OSEL, LOUT, ROUT, OIN, Rbus, DSEL,
        output DOUT, RESULT, WE, ZF, CF
    );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: two-stage execute pipeline with an 8-entry register file.
// Stage 1 reads operands, stage 2 runs the ALU, writes back and updates flags.
// Optional feature: define EXEC_BYPASS_EN to forward the stage-2 result into
// stage-1 operand reads (removes the one-instruction read-after-write hazard).
`ifndef OP_LOADI
`define OP_LOADI 4'h1
`endif
`ifndef OP_ADD
`define OP_ADD 4'h2
`endif
`ifndef OP_SUB
`define OP_SUB 4'h3
`endif

module exec_unit #(
    parameter int DW = 16
) (
    input  logic         clk,
    input  logic         res,
    exec_unit_if.slave   bus
);
    logic [7:0][DW-1:0] rf;

    // stage-2 pipeline registers
    logic [DW-1:0] a_q, b_q;
    logic [3:0]    op_q;
    logic [2:0]    osel_q;
    logic          oin_q;

    // architectural outputs
    logic [DW-1:0] result_q;
    logic          we_q, zf_q, cf_q;

    // ALU signals
    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic [DW:0]   sum_w, diff_w;

    // stage-1 operand selection
    logic [DW-1:0] l_val, r_val, a_d, b_d;

    // ALU on captured operands; diff_w[DW] is the unsigned borrow (A<B)
    always_comb begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q};
        diff_w  = {1'b0, a_q} - {1'b0, b_q};
        alu_res = a_q;
        alu_c   = 1'b0;
        case (op_q)
            `OP_LOADI: alu_res = b_q;
            `OP_ADD:   {alu_c, alu_res} = sum_w;
            `OP_SUB:   {alu_c, alu_res} = diff_w;
            default:   alu_res = a_q;
        endcase
    end

    // operand read, optionally forwarding the instruction now retiring
    always_comb begin
`ifdef EXEC_BYPASS_EN
        l_val = (oin_q && (osel_q == bus.LSEL)) ? alu_res : rf[bus.LSEL];
        r_val = (oin_q && (osel_q == bus.RSEL)) ? alu_res : rf[bus.RSEL];
`else
        l_val = rf[bus.LSEL];
        r_val = rf[bus.RSEL];
`endif
        a_d = bus.LOUT ? l_val : '0;
        b_d = bus.ROUT ? r_val : bus.Rbus;
    end

    // stage 1: capture operands and control for the next edge
    always_ff @(posedge clk) begin
        if (res) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            osel_q <= '0;
            oin_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= bus.OP;
            osel_q <= bus.OSEL;
            oin_q  <= bus.OIN;
        end
    end

    // stage 2: writeback, result, write pulse and flags; reset drops a pending write
    always_ff @(posedge clk) begin
        if (res) begin
            rf       <= '0;
            result_q <= '0;
            we_q     <= 1'b0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
        end else begin
            if (oin_q)
                rf[osel_q] <= alu_res;
            result_q <= alu_res;
            we_q     <= oin_q;
            if (op_q == `OP_ADD || op_q == `OP_SUB || op_q == `OP_LOADI)
                zf_q <= (alu_res == '0);
            if (op_q == `OP_ADD || op_q == `OP_SUB)
                cf_q <= alu_c;
        end
    end

    assign bus.DOUT   = rf[bus.DSEL];
    assign bus.RESULT = result_q;
    assign bus.WE     = we_q;
    assign bus.ZF     = zf_q;
    assign bus.CF     = cf_q;
endmodule
